// File: rtl/sad_window_unit.sv
// Purpose: SAD of a ROWS-row reference-frame block against a ROWS-row search-window block, fed by load shift strobes.
// Latency: zero; SAD_value/SAD_valid are combinational from inputs and state, rows and counters commit on Clk rise.
// Backpressure: none; shifts are accepted every cycle. Optional macro SAD_FILL_GUARD_EN forces all-ones until filled.
module sad_window_unit #(
    parameter int ROWS = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] MEM_SAD_ReadData,
    input  logic        frame_shift,
    input  logic        window_shift,
    output logic [31:0] SAD_value,
    output logic        SAD_valid
);

    // Fill counter wide enough to hold ROWS (3 bits for ROWS=4).
    localparam int CW = $clog2(ROWS + 1);
    // Sum width covering ROWS*4 pixels of 255 each (12 bits for ROWS=4).
    localparam int SW = $clog2(ROWS * 4 * 255 + 1);
    localparam logic [CW-1:0] FULL = CW'(ROWS);

    logic [31:0]   frame  [ROWS];
    logic [31:0]   window [ROWS];
    logic [CW-1:0] fcnt;
    logic [CW-1:0] wcnt;

    logic [31:0]   nf [ROWS];
    logic [31:0]   nw [ROWS];
    logic [CW-1:0] nfcnt;
    logic [CW-1:0] nwcnt;
    logic [SW-1:0] sad_sum;

    // Next block contents and fill counts: shift on strobe, hold otherwise, cleared while Reset is high.
    always_comb begin
        nf    = frame;
        nw    = window;
        nfcnt = fcnt;
        nwcnt = wcnt;
        if (frame_shift) begin
            for (int i = 0; i < ROWS - 1; i++) begin
                nf[i] = frame[i+1];
            end
            nf[ROWS-1] = MEM_SAD_ReadData;
            if (fcnt != FULL) begin
                nfcnt = fcnt + CW'(1);
            end
        end
        if (window_shift) begin
            for (int i = 0; i < ROWS - 1; i++) begin
                nw[i] = window[i+1];
            end
            nw[ROWS-1] = MEM_SAD_ReadData;
            if (wcnt != FULL) begin
                nwcnt = wcnt + CW'(1);
            end
        end
        if (Reset) begin
            for (int i = 0; i < ROWS; i++) begin
                nf[i] = '0;
                nw[i] = '0;
            end
            nfcnt = '0;
            nwcnt = '0;
        end
    end

    // Sum of unsigned absolute pixel differences over the post-update blocks; column 0 is the top byte.
    always_comb begin
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        sad_sum = '0;
        a       = '0;
        b       = '0;
        d       = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < 4; c++) begin
                a = nf[r][31 - 8*c -: 8];
                b = nw[r][31 - 8*c -: 8];
                d = (a > b) ? (a - b) : (b - a);
                sad_sum = sad_sum + SW'(d);
            end
        end
    end

    // Result is valid only once both blocks hold ROWS words loaded since Reset.
    always_comb begin
        SAD_valid = (nfcnt == FULL) && (nwcnt == FULL);
`ifdef SAD_FILL_GUARD_EN
        SAD_value = SAD_valid ? {{(32-SW){1'b0}}, sad_sum} : 32'hFFFF_FFFF;
`else
        SAD_value = {{(32-SW){1'b0}}, sad_sum};
`endif
    end

    // Commit block rows and fill counters; Reset wins over any strobe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < ROWS; i++) begin
                frame[i]  <= '0;
                window[i] <= '0;
            end
            fcnt <= '0;
            wcnt <= '0;
        end else begin
            frame  <= nf;
            window <= nw;
            fcnt   <= nfcnt;
            wcnt   <= nwcnt;
        end
    end

endmodule

// File: tb/tb_sad_window_unit.sv
// Purpose: randomized and directed checking of sad_window_unit against a queue-based reference model.
// Latency: outputs compared in the same cycle as the strobe, 1 ns after inputs settle at the falling edge.
// Backpressure: none; the bench may strobe every cycle.
module tb_sad_window_unit;

    localparam int ROWS = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] MEM_SAD_ReadData = '0;
    logic        frame_shift = 1'b0;
    logic        window_shift = 1'b0;
    logic [31:0] SAD_value;
    logic        SAD_valid;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: rows held as queues, oldest at the front.
    logic [31:0] fq[$];
    logic [31:0] wq[$];
    int          fc;
    int          wc;
    logic [31:0] exp_val;
    logic        exp_vld;

    sad_window_unit #(.ROWS(ROWS)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .MEM_SAD_ReadData (MEM_SAD_ReadData),
        .frame_shift      (frame_shift),
        .window_shift     (window_shift),
        .SAD_value        (SAD_value),
        .SAD_valid        (SAD_valid)
    );

    always #5 Clk = ~Clk;

    task automatic model_clear();
        fq = {};
        wq = {};
        for (int i = 0; i < ROWS; i++) begin
            fq.push_back(32'h0);
            wq.push_back(32'h0);
        end
        fc = 0;
        wc = 0;
    endtask

    function automatic logic [31:0] model_sad();
        int s = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < 4; c++) begin
                int a = int'((fq[r] >> (24 - 8*c)) & 32'hFF);
                int b = int'((wq[r] >> (24 - 8*c)) & 32'hFF);
                s += (a > b) ? a - b : b - a;
            end
        end
        return 32'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One cycle: drive at the falling edge, advance the model to post-update state, compare outputs.
    task automatic step(input bit rst, input bit fs, input bit ws, input logic [31:0] d);
        @(negedge Clk);
        Reset            = rst;
        frame_shift      = fs;
        window_shift     = ws;
        MEM_SAD_ReadData = d;
        if (rst) begin
            model_clear();
        end else begin
            if (fs) begin
                void'(fq.pop_front());
                fq.push_back(d);
                if (fc < ROWS) fc++;
            end
            if (ws) begin
                void'(wq.pop_front());
                wq.push_back(d);
                if (wc < ROWS) wc++;
            end
        end
        exp_vld = (fc == ROWS) && (wc == ROWS);
        exp_val = model_sad();
`ifdef SAD_FILL_GUARD_EN
        if (!exp_vld) exp_val = 32'hFFFF_FFFF;
`endif
        #1;
        check("sad_value", SAD_value, exp_val);
        check("sad_valid", {31'b0, SAD_valid}, {31'b0, exp_vld});
    endtask

    initial begin
        logic [31:0] reset_val;
        logic [31:0] sim_dat [4];
`ifdef SAD_FILL_GUARD_EN
        reset_val = 32'hFFFF_FFFF;
`else
        reset_val = 32'h0;
`endif
        sim_dat[0] = 32'hAABBCCDD;
        sim_dat[1] = 32'h01020304;
        sim_dat[2] = 32'h7F80FF00;
        sim_dat[3] = 32'h00000001;
        model_clear();

        // Reset state, no strobes.
        step(1, 0, 0, 32'hDEADBEEF);
        step(1, 0, 0, 32'h12345678);
        check("reset_value", SAD_value, reset_val);
        check("reset_valid", {31'b0, SAD_valid}, 32'h0);
        step(0, 0, 0, 32'hFFFFFFFF);
        check("idle_value", SAD_value, reset_val);

        // Basic fill: frame 0x10 pixels, window 0x0C pixels.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 32'h10101010);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h0C0C0C0C);
        check("fill_3rd_valid", {31'b0, SAD_valid}, 32'h0);
        step(0, 0, 1, 32'h0C0C0C0C);
        check("fill_4th_value", SAD_value, 32'h40);
        check("fill_4th_valid", {31'b0, SAD_valid}, 32'h1);
        step(0, 0, 0, 32'h55555555);
        check("hold_value", SAD_value, 32'h40);

        // Difference direction, both orders.
        step(1, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 32'h00FF0000);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'hFF000000);
        check("dir_fw", SAD_value, 32'h7F8);
        step(1, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 32'hFF000000);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h00FF0000);
        check("dir_wf", SAD_value, 32'h7F8);

        // Maximum sum.
        step(1, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 32'hFFFFFFFF);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h00000000);
        check("max_value", SAD_value, 32'hFF0);

        // Simultaneous strobes, then a window-only shift that misaligns the blocks.
        step(1, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, sim_dat[i]);
        check("sim_value", SAD_value, 32'h0);
        check("sim_valid", {31'b0, SAD_valid}, 32'h1);
        step(0, 0, 1, 32'h00000002);

        // Reset mid-fill with a frame strobe present.
        step(1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h11223344 + 32'(i));
        for (int i = 0; i < 2; i++) step(0, 0, 1, 32'h99887766 + 32'(i));
        step(1, 1, 0, 32'hCAFEF00D);
        check("midrst_value", SAD_value, reset_val);
        check("midrst_valid", {31'b0, SAD_valid}, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 32'h01010101);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h03030303);
        check("reload_3_valid", {31'b0, SAD_valid}, 32'h0);
        step(0, 0, 1, 32'h03030303);
        check("reload_4_valid", {31'b0, SAD_valid}, 32'h1);
        check("reload_4_value", SAD_value, 32'h20);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom), $urandom);
        end

        @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
